// File: rtl/semafor_scheduler.sv
`default_nettype none
// ============================================================================
// semafor_scheduler : main road / side road / pedestrian phase scheduler
// Rev 1.0
// ============================================================================
module semafor_scheduler #(
  parameter int T_GREEN_MIN = 5,
  parameter int T_GREEN_B   = 4,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 3,
  parameter int TMR_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_b,
  input  logic       btn_n,
  output logic       a_red,
  output logic       a_yellow,
  output logic       a_green,
  output logic       b_red,
  output logic       b_yellow,
  output logic       b_green,
  output logic       ped_walk,
  output logic       ped_wait,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    ALLRED1  = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    PED_WALK = 3'd5,
    ALLRED2  = 3'd6
  } phase_t;

  // Terminal count of each timed phase: the phase exits on the tick seen here.
  localparam logic [TMR_W-1:0] GMIN_LAST = TMR_W'(T_GREEN_MIN - 1);
  localparam logic [TMR_W-1:0] GB_LAST   = TMR_W'(T_GREEN_B - 1);
  localparam logic [TMR_W-1:0] YEL_LAST  = TMR_W'(T_YELLOW - 1);
  localparam logic [TMR_W-1:0] RED_LAST  = TMR_W'(T_ALLRED - 1);
  localparam logic [TMR_W-1:0] WALK_LAST = TMR_W'(T_WALK - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  phase_t           phase, phase_nx;
  logic [TMR_W-1:0] tmr, tmr_nx, dur_last;
  logic             b_pend, ped_pend, last_ped, sel_ped;
  logic             b_pend_nx, ped_pend_nx, last_ped_nx, sel_ped_nx;
  logic             clr_b, clr_p;
  logic             btn_s1, btn_s2, btn_s3, btn_fall;

  // Button synchronizer; btn_s3 only serves the falling-edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      btn_s3 <= 1'b1;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign btn_fall = btn_s3 & ~btn_s2;

  always_comb begin
    dur_last = GMIN_LAST;
    case (phase)
      A_YELLOW, B_YELLOW: dur_last = YEL_LAST;
      ALLRED1, ALLRED2:   dur_last = RED_LAST;
      B_GREEN:            dur_last = GB_LAST;
      PED_WALK:           dur_last = WALK_LAST;
      default:            dur_last = GMIN_LAST;
    endcase
  end

  always_comb begin
    phase_nx    = phase;
    tmr_nx      = tmr;
    sel_ped_nx  = sel_ped;
    last_ped_nx = last_ped;
    clr_b       = 1'b0;
    clr_p       = 1'b0;
    case (phase)
      A_GREEN: begin
        if (tick) begin
          if (tmr == GMIN_LAST) begin
            if (b_pend | ped_pend) begin
              phase_nx   = A_YELLOW;
              tmr_nx     = '0;
              // Pedestrian wins alone, or on a tie when B was served last.
              sel_ped_nx = ped_pend & (~b_pend | ~last_ped);
            end
          end else begin
            tmr_nx = tmr + TMR_ONE;
          end
        end
      end
      A_YELLOW, ALLRED1, B_GREEN, B_YELLOW, PED_WALK, ALLRED2: begin
        if (tick) begin
          if (tmr == dur_last) begin
            tmr_nx = '0;
            case (phase)
              A_YELLOW: phase_nx = ALLRED1;
              ALLRED1: begin
                if (sel_ped) begin
                  phase_nx    = PED_WALK;
                  clr_p       = 1'b1;
                  last_ped_nx = 1'b1;
                end else begin
                  phase_nx    = B_GREEN;
                  clr_b       = 1'b1;
                  last_ped_nx = 1'b0;
                end
              end
              B_GREEN:            phase_nx = B_YELLOW;
              B_YELLOW, PED_WALK: phase_nx = ALLRED2;
              default:            phase_nx = A_GREEN;
            endcase
          end else begin
            tmr_nx = tmr + TMR_ONE;
          end
        end
      end
      default: begin
        phase_nx = A_GREEN;
        tmr_nx   = '0;
      end
    endcase
  end

  // A request arriving in the same clk as its clear survives.
  assign b_pend_nx   = (b_pend & ~clr_b) | req_b;
  assign ped_pend_nx = (ped_pend & ~clr_p) | btn_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= A_GREEN;
      tmr      <= '0;
      b_pend   <= 1'b0;
      ped_pend <= 1'b0;
      last_ped <= 1'b1;
      sel_ped  <= 1'b0;
    end else begin
      phase    <= phase_nx;
      tmr      <= tmr_nx;
      b_pend   <= b_pend_nx;
      ped_pend <= ped_pend_nx;
      last_ped <= last_ped_nx;
      sel_ped  <= sel_ped_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_red    <= 1'b0;
      a_yellow <= 1'b0;
      a_green  <= 1'b1;
      b_red    <= 1'b1;
      b_yellow <= 1'b0;
      b_green  <= 1'b0;
      ped_walk <= 1'b0;
      ped_wait <= 1'b0;
    end else begin
      a_green  <= (phase == A_GREEN);
      a_yellow <= (phase == A_YELLOW);
      a_red    <= (phase != A_GREEN) && (phase != A_YELLOW);
      b_green  <= (phase == B_GREEN);
      b_yellow <= (phase == B_YELLOW);
      b_red    <= (phase != B_GREEN) && (phase != B_YELLOW);
      ped_walk <= (phase == PED_WALK);
      ped_wait <= ped_pend;
    end
  end

  assign state = phase;

endmodule

`default_nettype wire

// File: tb/tb_semafor_scheduler.sv
`default_nettype none
// ============================================================================
// tb_semafor_scheduler : directed + random bench with a tick-slot schedule model
// Rev 1.0
// ============================================================================
module tb_semafor_scheduler;

  localparam int TGM = 5;
  localparam int TGB = 4;
  localparam int TY  = 2;
  localparam int TAR = 1;
  localparam int TW  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       req_b = 1'b0;
  logic       btn_n = 1'b1;
  logic       a_red, a_yellow, a_green, b_red, b_yellow, b_green, ped_walk, ped_wait;
  logic [2:0] state;

  semafor_scheduler #(
    .T_GREEN_MIN(TGM), .T_GREEN_B(TGB), .T_YELLOW(TY),
    .T_ALLRED(TAR), .T_WALK(TW), .TMR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .req_b(req_b), .btn_n(btn_n),
    .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
    .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green),
    .ped_walk(ped_walk), .ped_wait(ped_wait), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the service sequence is a list of tick slots, one per tick.
  int         m_phase, m_gcnt;
  bit         m_bp, m_pp, m_last, m_s1, m_s2, m_s3;
  int         q[$];
  int         exp_state;
  logic [7:0] exp_lamps;

  int ticks_in[8];
  int svc[$];
  int n_walk;

  function automatic logic [7:0] lamps_of(input int ph, input bit pw);
    bit ag, ay, bg, by;
    ag = (ph == 0); ay = (ph == 1); bg = (ph == 3); by = (ph == 4);
    return {!(ag || ay), ay, ag, !(bg || by), by, bg, (ph == 5), pw};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_gcnt = 0; q.delete();
    m_bp = 0; m_pp = 0; m_last = 1;
    m_s1 = 1; m_s2 = 1; m_s3 = 1;
    exp_state = 0;
    exp_lamps = lamps_of(0, 1'b0);
  endtask

  task automatic model_step();
    bit fall, clr_b, clr_p, pick_ped;
    int old;
    if (!rst) begin
      model_reset();
      return;
    end
    exp_lamps = lamps_of(m_phase, m_pp);
    fall = m_s3 && !m_s2;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = btn_n;
    clr_b = 0; clr_p = 0; old = m_phase;
    if (tick) begin
      if (m_phase == 0) begin
        if (m_gcnt >= TGM - 1 && (m_bp || m_pp)) begin
          pick_ped = m_pp && (!m_bp || !m_last);
          q.delete();
          repeat (TY)  q.push_back(1);
          repeat (TAR) q.push_back(2);
          if (pick_ped) begin
            repeat (TW) q.push_back(5);
          end else begin
            repeat (TGB) q.push_back(3);
            repeat (TY)  q.push_back(4);
          end
          repeat (TAR) q.push_back(6);
          m_phase = q[0];
        end else begin
          m_gcnt++;
        end
      end else begin
        void'(q.pop_front());
        m_phase = (q.size() > 0) ? q[0] : 0;
      end
      if (m_phase != old) begin
        if (m_phase == 3) begin clr_b = 1; m_last = 0; end
        if (m_phase == 5) begin clr_p = 1; m_last = 1; end
        if (m_phase == 0) m_gcnt = 0;
      end
    end
    m_bp = (m_bp && !clr_b) || req_b;
    m_pp = (m_pp && !clr_p) || fall;
    exp_state = m_phase;
  endtask

  task automatic clear_stats();
    foreach (ticks_in[i]) ticks_in[i] = 0;
    svc.delete();
    n_walk = 0;
  endtask

  // Called at a negedge: drive inputs, clock once, compare at the next negedge.
  task automatic step(input bit t, input bit rb, input bit bn);
    logic [2:0] pre;
    pre = state;
    tick = t; req_b = rb; btn_n = bn;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (t && rst) ticks_in[pre]++;
    if (rst && state != pre) begin
      if (state == 3'd3) svc.push_back(0);
      if (state == 3'd5) begin svc.push_back(1); n_walk++; end
    end
    check_eq("state", 32'(state), 32'(exp_state));
    check_eq("lamps", 32'({a_red, a_yellow, a_green, b_red, b_yellow, b_green, ped_walk, ped_wait}),
             32'(exp_lamps));
    check_eq("one_lamp_a", int'(a_red) + int'(a_yellow) + int'(a_green), 1);
    check_eq("one_lamp_b", int'(b_red) + int'(b_yellow) + int'(b_green), 1);
    check_eq("go_excl", 32'((int'(a_green | a_yellow) + int'(b_green | b_yellow) + int'(ped_walk)) <= 1), 1);
  endtask

  task automatic do_reset();
    rst = 0;
    repeat (3) step(0, 0, 1);
    rst = 1;
    clear_stats();
  endtask

  int  tick_no, first_ay, first_wait, bb;
  bit  found, bn;

  initial begin
    model_reset();
    clear_stats();
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);

    // Reset and idle
    do_reset();
    check_eq("rst_state", 32'(state), 0);
    for (int i = 0; i < 200; i++) step(i % 10 == 9, 0, 1);
    check_eq("idle_state", 32'(state), 0);
    check_eq("idle_walks", n_walk, 0);

    // Single pedestrian press at tick 8
    do_reset();
    first_wait = -1;
    for (int i = 0; i < 400; i++) begin
      step(i % 10 == 9, 0, !(i >= 80 && i < 130));
      if (first_wait < 0 && ped_wait) first_wait = i;
    end
    check_eq("ped_wait_lat", 32'(first_wait >= 80 && first_wait - 80 <= 3), 1);
    check_eq("ped_ay_ticks", ticks_in[1], TY);
    check_eq("ped_ar1_ticks", ticks_in[2], TAR);
    check_eq("ped_walk_ticks", ticks_in[5], TW);
    check_eq("ped_ar2_ticks", ticks_in[6], TAR);
    check_eq("ped_walk_count", n_walk, 1);
    check_eq("ped_end_state", 32'(state), 0);

    // Minimum green enforced
    do_reset();
    tick_no = 0; first_ay = -1;
    for (int i = 0; i < 300; i++) begin
      step(i % 10 == 9, i == 9, 1);
      if (i % 10 == 9) tick_no++;
      if (first_ay < 0 && state == 3'd1) first_ay = tick_no;
    end
    check_eq("mingreen_tick", first_ay, TGM);
    check_eq("bgreen_ticks", ticks_in[3], TGB);
    check_eq("byellow_ticks", ticks_in[4], TY);

    // Tie alternation
    do_reset();
    for (int i = 0; i < 800; i++) step(i % 4 == 3, 1, !((i % 40) < 3));
    check_eq("tie_count", 32'(svc.size() >= 4), 1);
    if (svc.size() >= 4) begin
      check_eq("tie_svc0", svc[0], 0);
      check_eq("tie_svc1", svc[1], 1);
      check_eq("tie_svc2", svc[2], 0);
      check_eq("tie_svc3", svc[3], 1);
    end
    bb = 0;
    for (int k = 1; k < svc.size(); k++) if (svc[k] == 0 && svc[k-1] == 0) bb++;
    check_eq("tie_no_bb", bb, 0);

    // Held button
    do_reset();
    for (int i = 0; i < 400; i++) step(i % 4 == 3, 0, !(i < 160));
    check_eq("held_walks", n_walk, 1);

    // Reset mid-walk
    do_reset();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(i % 4 == 3, 0, !(i < 3));
      if (state == 3'd5 && ticks_in[5] == 1) found = 1;
    end
    check_eq("midwalk_reached", 32'(found), 1);
    #2 rst = 0;
    #1;
    check_eq("async_a_green", 32'(a_green), 1);
    check_eq("async_ped_walk", 32'(ped_walk), 0);
    check_eq("async_state", 32'(state), 0);
    model_reset();
    @(negedge clk);
    repeat (2) step(0, 0, 1);
    rst = 1;
    clear_stats();
    for (int i = 0; i < 300; i++) step(i % 4 == 3, 0, 1);
    check_eq("postrst_walks", n_walk, 0);

    // Random traffic
    do_reset();
    bn = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) bn = !bn;
      rst = ($urandom_range(0, 599) != 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, bn);
    end
    rst = 1;
    step(0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/semafor_scheduler.md
Name: semafor_scheduler

Overview:
- Intersection scheduler for a main road (A), a side road (B) and a pedestrian crossing.
- A holds green by default. Side-road vehicle requests and pedestrian button presses are latched, then served one at a time, round-robin between B and pedestrian. Amber and all-red clearance phases separate every service.
- Timing is driven by a one-cycle `tick` enable from the shared clock_divider, so all logic stays in the `clk` domain.

Parameters:
- T_GREEN_MIN, 5, minimum A green in ticks before a request may be served
- T_GREEN_B, 4, B green duration in ticks
- T_YELLOW, 2, amber duration in ticks (both roads)
- T_ALLRED, 1, all-red clearance in ticks
- T_WALK, 3, pedestrian walk duration in ticks
- TMR_W, 8, phase timer width; every T_* must be in 1..2^TMR_W-1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- tick  in  1  one-clk-wide timing enable
- req_b  in  1  side-road vehicle sensor, level, synchronous
- btn_n  in  1  pedestrian button, active-low, asynchronous
- a_red, a_yellow, a_green  out  1 each  main-road lamps
- b_red, b_yellow, b_green  out  1 each  side-road lamps
- ped_walk  out  1  pedestrian walk lamp
- ped_wait  out  1  pedestrian request pending
- state  out  3  current phase code

Behaviour:
- Reset: async assert on rst=0.
  - state=A_GREEN, tmr=0, b_pend=0, ped_pend=0, last_ped=1 (B wins the first tie).
  - Lamps: a_green=1, b_red=1, all other lamp outputs 0; ped_wait=0.
  - Synchronizer flops reset to 1.
- Phase codes:
  - A_GREEN=0, A_YELLOW=1, ALLRED1=2, B_GREEN=3, B_YELLOW=4, PED_WALK=5, ALLRED2=6.
  - 7 is illegal and returns to A_GREEN on the next clk with tmr=0.
- Button input:
  - btn_n passes through a 2-flop synchronizer.
  - A falling edge of the synchronized signal sets ped_pend. A held button yields one request.
  - req_b=1 on any clk sets b_pend.
- Phase timer:
  - tmr increments only on tick.
  - A timed phase of length T exits on the tick where tmr==T-1. tmr<=0 on every phase change, so each phase lasts exactly T ticks.
- A_GREEN:
  - tmr saturates at T_GREEN_MIN-1.
  - On a tick with tmr saturated and (b_pend|ped_pend): go to A_YELLOW and latch sel.
  - sel rules:
    - sel=PED if only ped_pend.
    - sel=B if only b_pend.
    - If both pending: sel=PED when last_ped=0, else sel=B.
  - A request arriving before the minimum green has elapsed waits; it does not shorten the minimum.
- A_YELLOW (T_YELLOW) -> ALLRED1 (T_ALLRED) -> B_GREEN if sel=B, else PED_WALK.
- Entering B_GREEN: clear b_pend, last_ped<=0. Sequence: B_GREEN (T_GREEN_B) -> B_YELLOW (T_YELLOW) -> ALLRED2.
- Entering PED_WALK: clear ped_pend, last_ped<=1. Sequence: PED_WALK (T_WALK) -> ALLRED2.
- ALLRED2 (T_ALLRED) -> A_GREEN.
- Simultaneous set/clear: a request set in the same clk its pending flag is cleared wins (flag stays 1). It is served on a later cycle.
- Lamp decode: lamps are registered outputs, updated the clk after the state change.
  - a_green in A_GREEN.
  - a_yellow in A_YELLOW.
  - a_red in all other phases.
  - b_green in B_GREEN; b_yellow in B_YELLOW; b_red otherwise.
  - ped_walk in PED_WALK only.
  - ped_wait = ped_pend, registered.
- Invariants:
  - At most one of green/yellow/walk is active across A, B and pedestrian at any time.
  - Exactly one lamp per road is lit.
- Reset mid-phase: immediate return to reset values; pending requests are lost.

Test Plan:
- Reset and idle:
  - Stimulus: rst=0 for 3 clk, then release; tick every 10 clk, no requests, 200 clk.
  - Required: state=0, a_green=1, b_red=1, ped_walk=0 throughout.
- Single pedestrian press:
  - Stimulus: btn_n low for 50 clk at tick 8 after reset.
  - Required: ped_wait=1 within 3 clk. Then A_YELLOW 2 ticks, ALLRED1 1 tick, PED_WALK 3 ticks (ped_walk=1, a_red=1), ALLRED2 1 tick, back to A_GREEN. ped_wait drops on PED_WALK entry.
- Minimum green enforced:
  - Stimulus: req_b pulse at tick 1 after reset.
  - Required: A_YELLOW entered only on tick 5, i.e. T_GREEN_MIN. B_GREEN then lasts exactly 4 ticks.
- Tie alternation:
  - Stimulus: req_b held high and a button pressed every 10 ticks.
  - Required: service order B, PED, B, PED. No two consecutive B services while ped_pend=1.
- Held button:
  - Stimulus: btn_n held low for 40 ticks.
  - Required: exactly one PED_WALK occurs.
- Reset mid-walk:
  - Stimulus: rst=0 during PED_WALK tick 2.
  - Required: ped_walk=0, a_green=1 asynchronously. No further PED_WALK without a new press.
